// File: rtl/crf_pkg.sv
// Shared types and default sizing for the camera-response-function lookup block.
package crf_pkg;

    typedef enum logic [1:0] {
        ST_BYPASS = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_LOAD   = 2'd2,
        ST_ACTIVE = 2'd3
    } crf_state_e;

    localparam int CRF_PIX_W    = 6;
    localparam int CRF_DATA_W   = 8;
    localparam int CRF_CHANNELS = 3;

    // Channel-select width; never zero so a single-channel build still has a port.
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/crf_lut_if.sv
// Pixel stream, result stream and table-configuration signals of crf_lut.
interface crf_lut_if
    import crf_pkg::*;
#(
    parameter int PIX_W    = CRF_PIX_W,
    parameter int DATA_W   = CRF_DATA_W,
    parameter int CHANNELS = CRF_CHANNELS,
    parameter int CH_W     = ch_width(CHANNELS)
) ();

    // Both streams use valid/ready: a beat transfers on a rising edge where
    // valid && ready; once valid is raised, valid and data hold until it transfers.
    logic                       in_valid;
    logic                       in_ready;
    logic [CHANNELS*PIX_W-1:0]  in_pixel;
    logic                       out_valid;
    logic                       out_ready;
    logic [CHANNELS*DATA_W-1:0] out_data;

    logic                       cfg_start;
    logic                       cfg_wr;
    logic [CH_W-1:0]            cfg_ch;
    logic [PIX_W-1:0]           cfg_addr;
    logic [DATA_W-1:0]          cfg_data;
    logic                       cfg_commit;
    logic                       cfg_busy;
    logic                       cfg_err;

    modport master (
        output in_valid, in_pixel, out_ready,
        output cfg_start, cfg_wr, cfg_ch, cfg_addr, cfg_data, cfg_commit,
        input  in_ready, out_valid, out_data, cfg_busy, cfg_err
    );

    modport slave (
        input  in_valid, in_pixel, out_ready,
        input  cfg_start, cfg_wr, cfg_ch, cfg_addr, cfg_data, cfg_commit,
        output in_ready, out_valid, out_data, cfg_busy, cfg_err
    );

endinterface

// File: rtl/crf_lut_ram.sv
// One channel's curve table: single write port, synchronous read with enable.
module crf_lut_ram #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // No reset on the array: curves survive rst and reloads.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/crf_lut.sv
// Per-channel camera response curve lookup with bypass mode and an in-band
// table reload sequence (drain the output, load entries, commit).
module crf_lut
    import crf_pkg::*;
#(
    parameter int PIX_W    = CRF_PIX_W,
    parameter int DATA_W   = CRF_DATA_W,
    parameter int CHANNELS = CRF_CHANNELS
) (
    input  logic       clk,
    input  logic       rst,
    crf_lut_if.slave   bus,
    output crf_state_e dbg_state
);

    localparam int PAD = DATA_W - PIX_W;

    generate
        if (PIX_W > DATA_W) begin : g_bad_width
            $error("crf_lut: PIX_W must not exceed DATA_W");
        end
    endgenerate

    crf_state_e                 state_q, state_d;
    logic                       out_valid_q;
    logic                       curve_q;
    logic [CHANNELS*DATA_W-1:0] pass_q, pass_d;
    logic [CHANNELS*DATA_W-1:0] rd_data;
    logic                       cfg_err_q;

    logic in_ready, accept, in_load, ch_ok, wr_ok, err_set;

    assign in_ready = ((state_q == ST_BYPASS) || (state_q == ST_ACTIVE))
                      && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign in_load  = (state_q == ST_LOAD);
    assign ch_ok    = (32'(bus.cfg_ch) < CHANNELS);
    assign wr_ok    = bus.cfg_wr && in_load && ch_ok;
    assign err_set  = (bus.cfg_wr && !wr_ok) || (bus.cfg_commit && !in_load);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BYPASS, ST_ACTIVE: if (bus.cfg_start) state_d = ST_DRAIN;
            ST_DRAIN:             if (!out_valid_q)  state_d = ST_LOAD;
            ST_LOAD:              if (bus.cfg_commit) state_d = ST_ACTIVE;
            default:              state_d = ST_BYPASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_BYPASS;
        else     state_q <= state_d;
    end

    // Left-justify each pixel code into its output lane.
    always_comb begin
        pass_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            pass_d[c*DATA_W +: DATA_W] = DATA_W'(bus.in_pixel[c*PIX_W +: PIX_W]) << PAD;
        end
    end

    // curve_q travels with the accepted pixel, so a reload never re-labels a held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            curve_q     <= 1'b0;
            pass_q      <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                out_valid_q <= 1'b1;
                curve_q     <= (state_q == ST_ACTIVE);
                pass_q      <= pass_d;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (err_set) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic we;
        assign we = wr_ok && (32'(bus.cfg_ch) == c);

        crf_lut_ram #(
            .ADDR_W (PIX_W),
            .DATA_W (DATA_W)
        ) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (bus.cfg_addr),
            .wdata (bus.cfg_data),
            .re    (accept),
            .raddr (bus.in_pixel[c*PIX_W +: PIX_W]),
            .rdata (rd_data[c*DATA_W +: DATA_W])
        );
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = curve_q ? rd_data : pass_q;
    assign bus.cfg_busy  = (state_q == ST_DRAIN) || (state_q == ST_LOAD);
    assign bus.cfg_err   = cfg_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_crf_lut.sv
// Directed bench for crf_lut: bypass, curve load/lookup, backpressure, drain,
// configuration errors and reset during a reload.
module tb_crf_lut;
    import crf_pkg::*;

    localparam int PIX_W  = 6;
    localparam int DATA_W = 8;
    localparam int CH     = 3;
    localparam int IW     = CH*PIX_W;
    localparam int OW     = CH*DATA_W;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    crf_state_e dbg_state;

    crf_lut_if #(.PIX_W(PIX_W), .DATA_W(DATA_W), .CHANNELS(CH)) bus ();

    crf_lut #(.PIX_W(PIX_W), .DATA_W(DATA_W), .CHANNELS(CH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [OW-1:0] exp_q[$];

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs();
        bus.in_valid   = 1'b0;
        bus.in_pixel   = '0;
        bus.out_ready  = 1'b1;
        bus.cfg_start  = 1'b0;
        bus.cfg_wr     = 1'b0;
        bus.cfg_ch     = '0;
        bus.cfg_addr   = '0;
        bus.cfg_data   = '0;
        bus.cfg_commit = 1'b0;
    endtask

    function automatic logic [IW-1:0] pix(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        return {b, g, r};
    endfunction

    task automatic send_pixel(input logic [IW-1:0] p);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_pixel = p;
        #1;
        while (!bus.in_ready && n < 20) begin
            tick();
            n++;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_pixel_ready: in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_state(input crf_state_e target, input int budget);
        int n;
        n = 0;
        while (dbg_state != target && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (dbg_state !== target) begin
            n_bad++;
            $display("FAIL wait_state: state=%0d required %0d", dbg_state, target);
        end
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [5:0] addr, input logic [7:0] data,
                             input logic commit);
        bus.cfg_wr     = 1'b1;
        bus.cfg_ch     = ch;
        bus.cfg_addr   = addr;
        bus.cfg_data   = data;
        bus.cfg_commit = commit;
        tick();
        bus.cfg_wr     = 1'b0;
        bus.cfg_commit = 1'b0;
    endtask

    task automatic pulse_start();
        bus.cfg_start = 1'b1;
        tick();
        bus.cfg_start = 1'b0;
    endtask

    task automatic pulse_commit();
        bus.cfg_commit = 1'b1;
        tick();
        bus.cfg_commit = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [OW-1:0] bypass_model(input logic [IW-1:0] p);
        logic [OW-1:0] r;
        for (int c = 0; c < CH; c++) begin
            r[c*DATA_W +: DATA_W] = {p[c*PIX_W +: PIX_W], 2'b00};
        end
        return r;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        init_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 24'h0) begin n_bad++; $display("FAIL reset_out_data: got %h required 000000", bus.out_data); end
        n_cmp++; if (bus.cfg_busy !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_busy: got %b required 0", bus.cfg_busy); end
        n_cmp++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_err: got %b required 0", bus.cfg_err); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        n_cmp++; if (dbg_state !== ST_BYPASS) begin n_bad++; $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_BYPASS); end
    endtask

    task automatic test_bypass();
        send_pixel(pix(6'h3F, 6'h01, 6'h20));
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bypass_valid: got %b required 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 24'h8004FC) begin n_bad++; $display("FAIL bypass_data0: got %h required 8004fc", bus.out_data); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bypass_clear: got %b required 0", bus.out_valid); end
        send_pixel(pix(6'h00, 6'h15, 6'h2A));
        n_cmp++; if (bus.out_data !== 24'hA85400) begin n_bad++; $display("FAIL bypass_data1: got %h required a85400", bus.out_data); end
        tick();
    endtask

    task automatic test_random_stream();
        int sent, rcvd, cyc;
        logic acc, take;
        logic [OW-1:0] got, expv;
        logic [IW-1:0] cur;
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 100 && cyc < 3000) begin
            if (!bus.in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_pixel = IW'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            acc  = bus.in_valid && bus.in_ready;
            take = bus.out_valid && bus.out_ready;
            got  = bus.out_data;
            cur  = bus.in_pixel;
            tick();
            cyc++;
            if (take) begin
                rcvd++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stream_extra: got %h with no pixel outstanding", got);
                end else begin
                    expv = exp_q.pop_front();
                    if (got !== expv) begin
                        n_bad++;
                        $display("FAIL stream_data: got %h required %h", got, expv);
                    end
                end
            end
            if (acc) begin
                exp_q.push_back(bypass_model(cur));
                sent++;
                bus.in_valid = 1'b0;
            end
        end
        n_cmp++;
        if (rcvd != 100 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL stream_count: received %0d left %0d required 100 and 0", rcvd, exp_q.size());
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
    endtask

    task automatic test_curve();
        pulse_start();
        n_cmp++; if (dbg_state !== ST_DRAIN) begin n_bad++; $display("FAIL curve_drain: got %0d required %0d", dbg_state, ST_DRAIN); end
        n_cmp++; if (bus.cfg_busy !== 1'b1) begin n_bad++; $display("FAIL curve_busy: got %b required 1", bus.cfg_busy); end
        wait_state(ST_LOAD, 4);
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL load_in_ready: got %b required 0", bus.in_ready); end
        cfg_write(2'd1, 6'h00, 8'h00, 1'b0);
        cfg_write(2'd1, 6'h01, 8'h04, 1'b0);
        cfg_write(2'd1, 6'h3F, 8'h47, 1'b0);
        cfg_write(2'd0, 6'h3F, 8'h11, 1'b0);
        cfg_write(2'd0, 6'h00, 8'h12, 1'b0);
        cfg_write(2'd2, 6'h20, 8'h33, 1'b0);
        cfg_write(2'd2, 6'h00, 8'h34, 1'b0);
        cfg_write(2'd2, 6'h01, 8'h35, 1'b1);
        n_cmp++; if (dbg_state !== ST_ACTIVE) begin n_bad++; $display("FAIL curve_active: got %0d required %0d", dbg_state, ST_ACTIVE); end
        n_cmp++; if (bus.cfg_busy !== 1'b0) begin n_bad++; $display("FAIL curve_not_busy: got %b required 0", bus.cfg_busy); end
        send_pixel(pix(6'h3F, 6'h3F, 6'h20));
        n_cmp++; if (bus.out_data !== 24'h334711) begin n_bad++; $display("FAIL curve_g3f: got %h required 334711", bus.out_data); end
        send_pixel(pix(6'h00, 6'h01, 6'h00));
        n_cmp++; if (bus.out_data !== 24'h340412) begin n_bad++; $display("FAIL curve_g01: got %h required 340412", bus.out_data); end
        send_pixel(pix(6'h00, 6'h00, 6'h01));
        n_cmp++; if (bus.out_data !== 24'h350012) begin n_bad++; $display("FAIL curve_wr_commit: got %h required 350012", bus.out_data); end
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        send_pixel(pix(6'h3F, 6'h3F, 6'h20));
        n_cmp++; if (bus.out_data !== 24'h334711) begin n_bad++; $display("FAIL bp_first: got %h required 334711", bus.out_data); end
        bus.in_valid = 1'b1;
        bus.in_pixel = pix(6'h00, 6'h01, 6'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b required 1", bus.out_valid); end
            n_cmp++; if (bus.out_data !== 24'h334711) begin n_bad++; $display("FAIL bp_hold: got %h required 334711", bus.out_data); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b required 0", bus.in_ready); end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_b2b_valid: got %b required 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 24'h340412) begin n_bad++; $display("FAIL bp_b2b_data: got %h required 340412", bus.out_data); end
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_clear: got %b required 0", bus.out_valid); end
    endtask

    task automatic test_drain();
        bus.out_ready = 1'b0;
        send_pixel(pix(6'h00, 6'h00, 6'h01));
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            bus.cfg_start = (i == 1);
            n_cmp++; if (dbg_state !== ST_DRAIN) begin n_bad++; $display("FAIL drain_state: got %0d required %0d", dbg_state, ST_DRAIN); end
            n_cmp++; if (bus.cfg_busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy: got %b required 1", bus.cfg_busy); end
            n_cmp++; if (bus.out_data !== 24'h350012) begin n_bad++; $display("FAIL drain_hold: got %h required 350012", bus.out_data); end
            tick();
        end
        bus.cfg_start = 1'b0;
        n_cmp++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL drain_start_err: got %b required 0", bus.cfg_err); end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL drain_handshake: got %b required 0", bus.out_valid); end
        n_cmp++; if (bus.cfg_busy !== 1'b1) begin n_bad++; $display("FAIL drain_busy_after: got %b required 1", bus.cfg_busy); end
        wait_state(ST_LOAD, 3);
        n_cmp++; if (bus.cfg_busy !== 1'b1) begin n_bad++; $display("FAIL load_busy: got %b required 1", bus.cfg_busy); end
        pulse_commit();
        n_cmp++; if (dbg_state !== ST_ACTIVE) begin n_bad++; $display("FAIL drain_commit: got %0d required %0d", dbg_state, ST_ACTIVE); end
    endtask

    task automatic test_cfg_err();
        cfg_write(2'd1, 6'h3F, 8'hAA, 1'b0);
        n_cmp++; if (bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_wr_active: got %b required 1", bus.cfg_err); end
        n_cmp++; if (dbg_state !== ST_ACTIVE) begin n_bad++; $display("FAIL err_wr_state: got %0d required %0d", dbg_state, ST_ACTIVE); end
        send_pixel(pix(6'h3F, 6'h3F, 6'h20));
        n_cmp++; if (bus.out_data !== 24'h334711) begin n_bad++; $display("FAIL err_wr_table: got %h required 334711", bus.out_data); end
        tick();
        pulse_reset();
        n_cmp++; if (bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_rst_clear: got %b required 0", bus.cfg_err); end
        pulse_commit();
        n_cmp++; if (bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_commit_bypass: got %b required 1", bus.cfg_err); end
        n_cmp++; if (dbg_state !== ST_BYPASS) begin n_bad++; $display("FAIL err_commit_state: got %0d required %0d", dbg_state, ST_BYPASS); end
        pulse_reset();
        pulse_start();
        wait_state(ST_LOAD, 4);
        cfg_write(2'd3, 6'h3F, 8'hAA, 1'b0);
        n_cmp++; if (bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_bad_ch: got %b required 1", bus.cfg_err); end
        n_cmp++; if (dbg_state !== ST_LOAD) begin n_bad++; $display("FAIL err_bad_ch_state: got %0d required %0d", dbg_state, ST_LOAD); end
        pulse_commit();
        send_pixel(pix(6'h3F, 6'h3F, 6'h20));
        n_cmp++; if (bus.out_data !== 24'h334711) begin n_bad++; $display("FAIL err_bad_ch_table: got %h required 334711", bus.out_data); end
        tick();
    endtask

    task automatic test_rst_mid_load();
        pulse_start();
        wait_state(ST_LOAD, 4);
        cfg_write(2'd1, 6'h02, 8'h99, 1'b0);
        pulse_reset();
        n_cmp++; if (dbg_state !== ST_BYPASS) begin n_bad++; $display("FAIL rst_load_state: got %0d required %0d", dbg_state, ST_BYPASS); end
        n_cmp++; if (bus.cfg_busy !== 1'b0) begin n_bad++; $display("FAIL rst_load_busy: got %b required 0", bus.cfg_busy); end
        send_pixel(pix(6'h3F, 6'h3F, 6'h20));
        n_cmp++; if (bus.out_data !== 24'h80FCFC) begin n_bad++; $display("FAIL rst_load_bypass: got %h required 80fcfc", bus.out_data); end
        tick();
        pulse_start();
        wait_state(ST_LOAD, 4);
        pulse_commit();
        send_pixel(pix(6'h00, 6'h01, 6'h00));
        n_cmp++; if (bus.out_data !== 24'h340412) begin n_bad++; $display("FAIL persist_g01: got %h required 340412", bus.out_data); end
        send_pixel(pix(6'h3F, 6'h3F, 6'h20));
        n_cmp++; if (bus.out_data !== 24'h334711) begin n_bad++; $display("FAIL persist_g3f: got %h required 334711", bus.out_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_random_stream();
        test_curve();
        test_backpressure();
        test_drain();
        test_cfg_err();
        test_rst_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
